// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, write-through, no-write-allocate
// cache. Owns the per-line valid bits, strobes the external negedge-clocked
// tag/data arrays, talks to memory over req/ack and counts hits and misses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for cpu_req; flush clears every valid bit here
//   S_LOOKUP | tag/data arrays read on the mid-cycle negedge, hit decided
//   S_MEM_RD | load miss, memory read outstanding
//   S_MEM_WR | store (hit or miss), memory write outstanding
//   S_FILL   | one-cycle array write (refill on load miss, update on store hit)
//   S_RESP   | one-cycle cpu_ready pulse
module cache_ctrl #(
  parameter int TAG_W  = 10,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = TAG_W + IDX_W + 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic [IDX_W-1:0]  tag_index,
  output logic              fetch_tag,
  output logic              update_tag,
  output logic [TAG_W-1:0]  tag_wdata,
  input  logic [TAG_W-1:0]  tag_rdata,
  output logic              dat_we,
  output logic [DATA_W-1:0] dat_wdata,
  input  logic [DATA_W-1:0] dat_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic              busy
);

  localparam int LINES = 2 ** IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_FILL, S_RESP
  } state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic                r_we;
  logic                r_hit;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_hit;
  logic                w_unused_ofs;

  // Tag compare against the array output that settled on the mid-cycle negedge
  assign w_hit        = r_valid[r_idx] && (tag_rdata == r_tag);
  // Byte offset bits play no part in a word-wide cache
  assign w_unused_ofs = ^cpu_addr[1:0];

  // Controller FSM; every output is a register so the arrays and memory see clean strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_hit      <= 1'b0;
      r_wdata    <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      tag_index  <= '0;
      fetch_tag  <= 1'b0;
      update_tag <= 1'b0;
      tag_wdata  <= '0;
      dat_we     <= 1'b0;
      dat_wdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            // Flush wins; a pending request is picked up on the next cycle
            r_valid <= '0;
          end else if (cpu_req) begin
            r_tag     <= cpu_addr[ADDR_W-1:IDX_W+2];
            r_idx     <= cpu_addr[IDX_W+1:2];
            r_we      <= cpu_we;
            r_wdata   <= cpu_wdata;
            tag_index <= cpu_addr[IDX_W+1:2];
            fetch_tag <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          fetch_tag <= 1'b0;
          r_hit     <= w_hit;
          if (w_hit) begin
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
          if (r_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {r_tag, r_idx, 2'b00};
            mem_wdata <= r_wdata;
            r_state   <= S_MEM_WR;
          end else if (w_hit) begin
            cpu_rdata <= dat_rdata;
            cpu_ready <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {r_tag, r_idx, 2'b00};
            r_state  <= S_MEM_RD;
          end
        end

        S_MEM_RD: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            cpu_rdata  <= mem_rdata;
            dat_wdata  <= mem_rdata;
            dat_we     <= 1'b1;
            update_tag <= 1'b1;
            tag_wdata  <= r_tag;
            r_state    <= S_FILL;
          end
        end

        S_MEM_WR: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (r_hit) begin
              // Keep the cached copy coherent with the write-through
              dat_we    <= 1'b1;
              dat_wdata <= r_wdata;
              r_state   <= S_FILL;
            end else begin
              cpu_ready <= 1'b1;
              r_state   <= S_RESP;
            end
          end
        end

        S_FILL: begin
          dat_we     <= 1'b0;
          dat_wdata  <= '0;
          update_tag <= 1'b0;
          tag_wdata  <= '0;
          if (!r_we) r_valid[r_idx] <= 1'b1;
          cpu_ready  <= 1'b1;
          r_state    <= S_RESP;
        end

        S_RESP: begin
          cpu_ready <= 1'b0;
          busy      <= 1'b0;
          tag_index <= '0;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: models the negedge tag/data arrays and a
// req/ack memory, predicts each transaction from cache-policy rules and checks
// the controller every cycle from a single negedge checker.
module tb_cache_ctrl;

  localparam int TAG_W  = 10;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 32;
  localparam int ADDR_W = TAG_W + IDX_W + 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flush = 1'b0;
  logic [IDX_W-1:0]  tag_index;
  logic              fetch_tag;
  logic              update_tag;
  logic [TAG_W-1:0]  tag_wdata;
  logic [TAG_W-1:0]  tag_rdata = '0;
  logic              dat_we;
  logic [DATA_W-1:0] dat_wdata;
  logic [DATA_W-1:0] dat_rdata = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;
  logic              busy;

  cache_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .flush(flush),
    .tag_index(tag_index), .fetch_tag(fetch_tag), .update_tag(update_tag),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .dat_we(dat_we), .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit   [63:0]       m_valid = '0;
  logic [TAG_W-1:0]  m_tag  [64];
  logic [DATA_W-1:0] m_data [64];
  int                m_hit = 0, m_miss = 0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];

  // per-transaction expectations
  bit                exp_mem, exp_mem_we, exp_fill, exp_upd;
  logic [ADDR_W-1:0] exp_mem_addr;
  logic [DATA_W-1:0] exp_mem_wdata, exp_dwdata;
  logic [TAG_W-1:0]  exp_tag;
  logic [IDX_W-1:0]  exp_idx;
  int                exp_lat;
  int                ack_delay = 1000;
  int                ready_cnt = 0;
  int                spur_req = 0, spur_done = 0;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {14'h0, a} ^ 32'hA5A5_0000;
  endfunction

  task automatic predict(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int nd, input bit fl);
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tg;
    logic [ADDR_W-1:0] wa;
    bit                hit;
    idx = addr[7:2];
    tg  = addr[17:8];
    wa  = {addr[17:2], 2'b00};
    if (fl) m_valid = '0;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin if (m_hit < 65535) m_hit++; end
    else begin if (m_miss < 65535) m_miss++; end
    exp_idx       = idx;
    exp_mem       = we || !hit;
    exp_mem_we    = we;
    exp_mem_addr  = wa;
    exp_mem_wdata = wd;
    exp_fill      = 1'b0;
    exp_upd       = 1'b0;
    exp_tag       = tg;
    if (!we) begin
      if (hit) begin
        m_rdata = m_data[idx];
        exp_lat = 2;
      end else begin
        m_rdata     = mem_rd(wa);
        m_valid[idx] = 1'b1;
        m_tag[idx]  = tg;
        m_data[idx] = m_rdata;
        exp_fill    = 1'b1;
        exp_upd     = 1'b1;
        exp_dwdata  = m_rdata;
        exp_lat     = nd + 3;
      end
    end else begin
      exp_fill   = hit;
      exp_dwdata = wd;
      if (hit) m_data[idx] = wd;
      exp_lat = hit ? nd + 3 : nd + 2;
    end
    ack_delay = nd;
  endtask

  // ---------------- environment: arrays and memory ----------------
  logic [TAG_W-1:0]  tarr [64];
  logic [DATA_W-1:0] darr [64];

  // Negedge-clocked tag/data arrays
  initial begin
    for (int i = 0; i < 64; i++) begin
      tarr[i] = '0;
      darr[i] = 32'hBAD0_0000 | i;
    end
    forever begin
      @(negedge clk);
      if (fetch_tag) begin
        tag_rdata = tarr[tag_index];
        dat_rdata = darr[tag_index];
      end
      if (update_tag) tarr[tag_index] = tag_wdata;
      if (dat_we)     darr[tag_index] = dat_wdata;
    end
  end

  // Memory responder: ack lands on the ack_delay-th edge after mem_req rises
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && rstn) begin
        cnt++;
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_rd(mem_addr);
        end
      end else begin
        cnt = 0;
      end
      if (spur_req != spur_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        spur_done = spur_req;
      end
    end
  end

  // ---------------- per-cycle checker ----------------
  initial begin
    int n, start, seen_fill;
    bit pb, seen_mem;
    n = 0; start = 0; seen_fill = 0; pb = 0; seen_mem = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pb = 0;
        continue;
      end
      n++;
      if (busy && !pb) begin
        start = n; seen_mem = 0; seen_fill = 0;
        chk("lookup_fetch_tag", fetch_tag, 1);
        chk("lookup_index", tag_index, exp_idx);
      end else if (fetch_tag) begin
        chk("fetch_outside_lookup", fetch_tag, 0);
      end
      pb = busy;
      if (!busy) chk("idle_index", tag_index, 0);
      if (mem_req) begin
        seen_mem = 1;
        chk("mem_addr", mem_addr, exp_mem_addr);
        chk("mem_we", mem_we, exp_mem_we);
        if (exp_mem_we) chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (dat_we || update_tag) begin
        seen_fill++;
        chk("fill_dat_we", dat_we, 1);
        chk("fill_update_tag", update_tag, exp_upd);
        chk("fill_dat_wdata", dat_wdata, exp_dwdata);
        chk("fill_index", tag_index, exp_idx);
        if (update_tag) begin
          chk("fill_tag_wdata", tag_wdata, exp_tag);
          chk("fetch_with_update", fetch_tag, 0);
        end
      end
      if (cpu_ready) begin
        ready_cnt++;
        chk("latency", n - start + 1, exp_lat);
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("mem_used", seen_mem, exp_mem);
        chk("fill_count", seen_fill, exp_fill);
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input int nd, input bit fl_with, input bit fl_busy);
    bit got;
    predict(we, addr, wd, nd, fl_with);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; flush = fl_with;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (fl_with) begin
        chk("flush_priority_busy", busy, 0);
        flush = 1'b0;
        fl_with = 0;
      end else if (fl_busy && busy) begin
        flush = 1'b1;
      end
      if (cpu_ready) begin
        got = 1;
        break;
      end
    end
    cpu_req = 1'b0;
    flush   = 1'b0;
    if (!got) chk("txn_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int rc;
    bit seen;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_fetch_tag", fetch_tag, 0);
    chk("rst_dat_we", dat_we, 0);
    mem_model[18'h00104] = 32'hDEAD_BEEF;
    mem_model[18'h10104] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // cold load miss, then hit
    run_txn(0, 18'h00104, 0, 3, 0, 0);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_miss_cnt", miss_cnt, 1);
    run_txn(0, 18'h00104, 0, 1, 0, 0);
    chk("t2_hit_cnt", hit_cnt, 1);

    // conflict on index 1
    run_txn(0, 18'h10104, 0, 2, 0, 0);
    chk("t3_rdata", cpu_rdata, 32'h1234_5678);
    run_txn(0, 18'h00104, 0, 1, 0, 0);
    chk("t3_miss_cnt", miss_cnt, 3);

    // store hit updates the line
    run_txn(1, 18'h00104, 32'h55, 2, 0, 0);
    run_txn(0, 18'h00104, 0, 1, 0, 0);
    chk("t4_rdata", cpu_rdata, 32'h55);
    chk("t4_hit_cnt", hit_cnt, 3);

    // store miss does not allocate
    run_txn(1, 18'h003F0, 32'hCAFE, 1, 0, 0);
    run_txn(0, 18'h003F0, 0, 2, 0, 0);
    chk("t5_rdata", cpu_rdata, 32'hCAFE);
    chk("t5_miss_cnt", miss_cnt, 5);

    // flush while busy is ignored
    run_txn(0, 18'h00104, 0, 1, 0, 1);
    chk("t6_hit_cnt", hit_cnt, 4);

    // stray ack in idle
    rc = ready_cnt;
    spur_req++;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_busy", busy, 0);
    chk("spur_mem_req", mem_req, 0);
    chk("spur_ready", ready_cnt, rc);
    chk("spur_rdata", cpu_rdata, m_rdata);

    // flush together with request
    run_txn(0, 18'h00104, 0, 2, 1, 0);
    chk("t7_miss_cnt", miss_cnt, 6);
    run_txn(0, 18'h003F0, 0, 1, 0, 0);
    run_txn(1, 18'h003F0, 32'hA1, 5, 0, 0);

    // reset while waiting for memory
    predict(0, 18'h02208, 0, 1000, 0);
    cpu_we = 1'b0; cpu_addr = 18'h02208; cpu_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (mem_req) begin seen = 1; break; end
    end
    chk("rst_reached_mem_rd", seen, 1);
    rc = ready_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_hit_cnt", hit_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    cpu_req = 1'b0;
    m_valid = '0; m_hit = 0; m_miss = 0; m_rdata = '0;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_ready", ready_cnt, rc);
    chk("mid_rst_rdata", cpu_rdata, 0);

    // valid bits were cleared by reset
    run_txn(0, 18'h003F0, 0, 2, 0, 0);
    chk("t8_miss_cnt", miss_cnt, 1);
    chk("t8_rdata", cpu_rdata, 32'hA1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
